// File: rtl/pool_pkg.sv
// Shared constants and helpers for the 2x2 max-pool / ReLU stage.
package pool_pkg;

  localparam int DW        = 32;
  localparam int IMG_W_DEF = 26;
  localparam int IMG_H_DEF = 26;
  localparam int IDX_W     = $clog2(IMG_W_DEF / 2);

  // Signed maximum; ties return a (values are identical anyway).
  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW-1:0] sa;
    logic signed [DW-1:0] sb;
    sa = a;
    sb = b;
    return (sb > sa) ? b : a;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Line buffer holding the horizontal pair maxima of the last even row.
// Synchronous write, combinational read; no reset (every entry is written before it is read).
module pool_linebuf
  import pool_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF / 2,
  parameter int AW    = IDX_W,
  parameter int W     = DW
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pool2x2_relu.sv
// 2x2 stride-2 max-pool of a raster-order conv map, one output per window, 1-cycle latency, no backpressure.
// Define POOL_RELU_EN to clamp each sample to max(sample, 0) before pooling.
module pool2x2_relu #(
  parameter int IMG_W = pool_pkg::IMG_W_DEF,
  parameter int IMG_H = pool_pkg::IMG_H_DEF,
  parameter int DW    = pool_pkg::DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_row,
  output logic [3:0]    out_col,
  output logic          frame_done
);
  import pool_pkg::*;

  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DEPTH = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [DW-1:0] r_hold;

  logic [DW-1:0] w_v;
  logic [DW-1:0] w_pmax;
  logic [DW-1:0] w_lb_rd;
  logic [AW-1:0] w_lb_addr;
  logic [XW-1:0] w_pcol;
  logic [YW-1:0] w_prow;
  logic          w_x_last;
  logic          w_y_last;
  logic          w_lb_we;
  logic          w_emit;
  logic          w_last_win;

`ifdef POOL_RELU_EN
  assign w_v = in_data[DW-1] ? '0 : in_data;
`else
  assign w_v = in_data;
`endif

  assign w_pmax    = smax(r_hold, w_v);
  assign w_pcol    = r_x >> 1;
  assign w_prow    = r_y >> 1;
  assign w_lb_addr = AW'(w_pcol);
  assign w_x_last  = (r_x == XW'(IMG_W - 1));
  assign w_y_last  = (r_y == YW'(IMG_H - 1));

  // Odd x is always a complete pair, so a trailing odd column never reaches here.
  assign w_lb_we    = in_valid & r_x[0] & ~r_y[0];
  assign w_emit     = in_valid & r_x[0] &  r_y[0];
  assign w_last_win = (w_prow == YW'(IMG_H / 2 - 1)) && (w_pcol == XW'(IMG_W / 2 - 1));

  pool_linebuf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (DW)
  ) u_linebuf (
    .clk       (clk),
    .i_wr_en   (w_lb_we),
    .i_wr_addr (w_lb_addr),
    .i_wr_data (w_pmax),
    .i_rd_addr (w_lb_addr),
    .o_rd_data (w_lb_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_hold <= '0;
    end else if (in_valid) begin
      if (!r_x[0]) r_hold <= w_v;
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      out_valid  <= w_emit;
      frame_done <= w_emit & w_last_win;
      if (w_emit) begin
        out_data <= smax(w_lb_rd, w_pmax);
        out_row  <= 4'(w_prow);
        out_col  <= 4'(w_pcol);
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_relu.sv
// Scoreboard bench for pool2x2_relu: a 26x26 instance and a 5x5 instance sharing clock and reset.
`timescale 1ns/1ps
module tb_pool2x2_relu;

`ifdef POOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    logic [3:0]  r;
    logic [3:0]  c;
    logic        fd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid, frame_done;
  logic [31:0] out_data;
  logic [3:0]  out_row, out_col;

  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_out_valid, s_frame_done;
  logic [31:0] s_out_data;
  logic [3:0]  s_out_row, s_out_col;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int mx = 0, my = 0, sx = 0, sy = 0;
  exp_t q_main[$];
  exp_t q_small[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool2x2_relu dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .frame_done(frame_done)
  );

  pool2x2_relu #(.IMG_W(5), .IMG_H(5)) dut_s (
    .clk(clk), .reset_n(reset_n), .in_valid(s_valid), .in_data(s_data),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_row(s_out_row),
    .out_col(s_out_col), .frame_done(s_frame_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents an output.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      checks++;
      if (q_main.size() == 0) begin
        errors++;
        $display("FAIL main_unexpected: out %0h at (%0d,%0d) cyc %0d", out_data, out_row, out_col, cyc);
      end else begin
        e = q_main.pop_front();
        if (out_data !== e.d || out_row !== e.r || out_col !== e.c || frame_done !== e.fd || cyc != e.cyc) begin
          errors++;
          $display("FAIL main_out: got d=%0h r=%0d c=%0d fd=%0b cyc=%0d expected d=%0h r=%0d c=%0d fd=%0b cyc=%0d",
                   out_data, out_row, out_col, frame_done, cyc, e.d, e.r, e.c, e.fd, e.cyc);
        end
      end
    end else if (frame_done) begin
      checks++;
      errors++;
      $display("FAIL main_fd_alone: frame_done=1 with out_valid=0 at cyc %0d", cyc);
    end
    if (frame_done) fd_cnt++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (s_out_valid) begin
      checks++;
      if (q_small.size() == 0) begin
        errors++;
        $display("FAIL small_unexpected: out %0h at (%0d,%0d)", s_out_data, s_out_row, s_out_col);
      end else begin
        e = q_small.pop_front();
        if (s_out_data !== e.d || s_out_row !== e.r || s_out_col !== e.c || s_frame_done !== e.fd || cyc != e.cyc) begin
          errors++;
          $display("FAIL small_out: got d=%0h r=%0d c=%0d fd=%0b cyc=%0d expected d=%0h r=%0d c=%0d fd=%0b cyc=%0d",
                   s_out_data, s_out_row, s_out_col, s_frame_done, cyc, e.d, e.r, e.c, e.fd, e.cyc);
        end
      end
    end
  end

  // e is the expected pooled value, used only when the sample closes a window.
  task automatic send_main(input logic [31:0] d, input logic [31:0] e, input int gap);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (mx % 2 == 1 && my % 2 == 1)
      q_main.push_back('{e, 4'(my / 2), 4'(mx / 2), (my / 2 == 12) && (mx / 2 == 12), cyc});
    if (mx == 25) begin
      mx = 0;
      my = (my == 25) ? 0 : my + 1;
    end else mx++;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_small(input logic [31:0] d, input logic [31:0] e);
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
    if (sx % 2 == 1 && sy % 2 == 1 && sx < 4 && sy < 4)
      q_small.push_back('{e, 4'(sy / 2), 4'(sx / 2), (sy == 3) && (sx == 3), cyc});
    if (sx == 4) begin
      sx = 0;
      sy = (sy == 4) ? 0 : sy + 1;
    end else sx++;
  endtask

  // Ramp y*26+x+off: each window's max is its bottom-right sample (2r+1)*26+2c+1+off.
  task automatic ramp_main(input int off, input int n, input int maxgap);
    int d, e;
    for (int i = 0; i < n; i++) begin
      d = off + my * 26 + mx;
      e = off + (2 * (my / 2) + 1) * 26 + 2 * (mx / 2) + 1;
      send_main(32'(d), 32'(e), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mx = 0; my = 0; sx = 0; sy = 0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_rowcol", 64'({out_row, out_col}), 64'd0);
    chk("rst_small_outs", 64'({s_out_valid, s_frame_done, s_out_data, s_out_row, s_out_col}), 64'd0);
    chk("rst_pending_main", 64'(q_main.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Signed window {-5,-3 / -9,-7}
    send_main(-32'sd5, 0, 0);
    send_main(-32'sd3, 0, 0);
    for (int i = 0; i < 24; i++) send_main(-32'sd100, 0, 0);
    send_main(-32'sd9, 0, 0);
    send_main(-32'sd7, RELU ? 32'd0 : -32'sd3, 0);
    @(posedge clk); #1;
    do_reset();

    // Most negative value everywhere
    for (int i = 0; i < 27; i++) send_main(32'h8000_0000, 0, 0);
    send_main(32'h8000_0000, RELU ? 32'd0 : 32'h8000_0000, 1);
    do_reset();

    ramp_main(0, 676, 0);
    ramp_main(0, 676, 5);

    // Mid-frame reset after 300 samples, then a clean frame
    ramp_main(0, 300, 0);
    do_reset();
    ramp_main(0, 676, 0);

    // Back-to-back frames
    repeat (2) @(posedge clk);
    #1;
    fd_cnt = 0;
    ramp_main(0, 676, 0);
    ramp_main(1000, 676, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_frame_done_count", 64'(fd_cnt), 64'd2);

    // 5x5 floor pooling: outputs 6, 8, 16, 18
    for (int i = 0; i < 25; i++)
      send_small(32'(i), 32'((2 * ((i / 5) / 2) + 1) * 5 + 2 * ((i % 5) / 2) + 1));
    repeat (3) @(posedge clk);
    #1;

    chk("main_queue_drained", 64'(q_main.size()), 64'd0);
    chk("small_queue_drained", 64'(q_small.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
